z80_tube_bridge_p: RTL and testbench
====================================

Name: z80_tube_bridge_p

Overview:
Parametrised Z80-host to Tube-ULA bridge with an on-chip GPIO/control register block; successor to the fixed-timing bridge.
- Decodes a 16-entry IO window and sequences Tube accesses with a programmable setup and PHI2-high width.
- Drives its own WAIT request to the host, latches Tube read data, and generates host interrupts from the Tube interrupt line.
- Split-direction buses; tristating is done in the top level.

Parameters:
PORT_TOP12, 12'hFC1, upper 12 IO-address bits of the window (base = PORT_TOP12<<4).
GPIO_W, 8, GPIO width, 1..8; unused register bits read 0.
SETUP_CYC, 1, CLK cycles with CS_B low and PHI2 low before PHI2 rises (>=1).
PHI2_HI_CYC, 2, CLK cycles PHI2 is high (>=1).
RST_CYC, 16, length in CLK cycles of a software Tube reset pulse (>=1).

Ports:
CLK  in  1  single clock; all state on rising edge.
RESET  in  1  synchronous, active-high reset.
ADR  in  16  host address.
IOREQ_B, RD_B, WR_B  in  1 each  host strobes, active low.
DATA_IN  in  8  host write data.
DATA_OUT  out  8  host read data.
DATA_OE  out  1  host data-bus drive enable.
WAIT_REQ  out  1  high = pull host WAIT* low.
INT_B  out  1  host interrupt, active low.
TUBE_ADR  out  3  Tube register select.
TUBE_CS_B, TUBE_RNW_B, TUBE_PHI2, TUBE_RST_B  out  1 each  Tube control.
TUBE_DIN  in  8  Tube read data.
TUBE_DOUT  out  8  Tube write data.
TUBE_DOE  out  1  Tube data-bus drive enable.
TUBE_INT_B  in  1  Tube interrupt, active low, asynchronous.
GPIO_IN  in  GPIO_W  pad input.
GPIO_OUT  out  GPIO_W  pad output.
GPIO_OE  out  GPIO_W  per-bit output enable.

Behaviour:
Reset values (RESET high at a rising edge):
- Outputs: TUBE_CS_B=1, TUBE_RNW_B=1, TUBE_PHI2=0, TUBE_DOE=0, WAIT_REQ=0, INT_B=1, DATA_OE=0, GPIO_OE=0, GPIO_OUT=0, TUBE_RST_B=0.
- Registers: FSM=IDLE, CTRL=0, pending=0, rd_latch=0.
- TUBE_RST_B held low for RST_CYC cycles after RESET falls.
- RESET mid-access aborts the access immediately.

Address decode: sel = IOREQ_B==0 && ADR[15:4]==PORT_TOP12 && (RD_B==0 || WR_B==0). ADR[3:0] selects the register:
- 0-7: Tube registers.
- 8: STATUS (read). bit0 = synced TUBE_INT level (1 = asserted); bit1 = pending (sticky); bit2 = busy (FSM != IDLE). Writing 1 to bit1 clears pending.
- 9: CTRL (R/W). bit0 = int enable. bit1 = write-1 starts the software reset pulse; reads 1 while the pulse runs.
- E: DIR (R/W), GPIO_OE.
- F: DATA. Write sets GPIO_OUT; read returns GPIO_IN.
- A-D: read 0, writes ignored.

Local register reads and writes:
- Reads are combinational: DATA_OE=sel&&!RD_B&&ADR[3]==1.
- Writes take effect on the first rising edge with sel&&!WR_B, and only once per IOREQ_B low period (edge-detected).

Tube FSM (IDLE, SETUP, PHI, DONE):
- IDLE->SETUP when sel&&ADR[3]==0, first cycle seen. Register ADR[2:0] and RNW=WR_B to TUBE_ADR and TUBE_RNW_B. TUBE_CS_B=0 from SETUP through PHI. WAIT_REQ=1 combinationally in that first cycle and in SETUP and PHI.
- SETUP: count SETUP_CYC cycles, then go to PHI.
- PHI: TUBE_PHI2=1 for PHI2_HI_CYC cycles. On writes, TUBE_DOE=1 and TUBE_DOUT=DATA_IN. On the last PHI cycle, rd_latch<=TUBE_DIN. Then go to DONE.
- DONE: CS_B=1, PHI2=0, WAIT_REQ=0. DATA_OUT=rd_latch with DATA_OE=1 while sel&&!RD_B. Go to IDLE when IOREQ_B is high.
- Total wait = 1+SETUP_CYC+PHI2_HI_CYC cycles. The counter is sized with clog2 of the maximum count.

Interrupts:
- TUBE_INT_B is synchronised by two flops.
- pending sets on the falling edge of the synced signal.
- If set and clear happen in the same cycle, set wins.
- INT_B = !(pending && CTRL.bit0).

Software reset:
- Down-counter loaded with RST_CYC. TUBE_RST_B=0 while it is non-zero.
- Rewriting during a pulse restarts the count.

Test Plan:
- Reset then idle: all outputs at reset values; TUBE_RST_B low exactly 16 cycles after RESET falls.
- OUT (&FC13),&5A with SETUP_CYC=1, PHI2_HI_CYC=2: WAIT_REQ high 4 cycles; CS_B low 3; PHI2 high 2 with TUBE_DOUT=&5A, TUBE_ADR=3, RNW_B=0.
- IN (&FC15) with TUBE_DIN=&A7: DATA_OUT=&A7 and DATA_OE=1 after WAIT_REQ drops, until IOREQ_B rises; FSM back to IDLE.
- GPIO_W=4: write DIR=&FF, DATA=&0C -> GPIO_OE=4'hF, GPIO_OUT=4'hC; read DIR returns &0F.
- TUBE_INT_B falls with CTRL=1: INT_B low 3 cycles later; STATUS reads &03. Write &02 to STATUS while TUBE_INT_B is still low -> pending clear, INT_B=1. A second falling edge coinciding with a clear leaves pending=1.
- RESET asserted during PHI: next cycle CS_B=1, PHI2=0, WAIT_REQ=0, FSM=IDLE. Write CTRL=&02 -> TUBE_RST_B low 16 cycles.

Source files
------------

// File: rtl/z80_tube_bridge_p.sv
// Z80 IO-window bridge to a Tube ULA, with status/control and GPIO registers.
// Latency: Tube access holds host WAIT for 1+SETUP_CYC+PHI2_HI_CYC cycles; local registers need no wait.
// Backpressure: WAIT_REQ stretches the host cycle; the FSM re-arms only once IOREQ_B returns high.
module z80_tube_bridge_p #(
  parameter logic [11:0] PORT_TOP12  = 12'hFC1,
  parameter int          GPIO_W      = 8,
  parameter int          SETUP_CYC   = 1,
  parameter int          PHI2_HI_CYC = 2,
  parameter int          RST_CYC     = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       ADR,
  input  logic              IOREQ_B,
  input  logic              RD_B,
  input  logic              WR_B,
  input  logic [7:0]        DATA_IN,
  output logic [7:0]        DATA_OUT,
  output logic              DATA_OE,
  output logic              WAIT_REQ,
  output logic              INT_B,
  output logic [2:0]        TUBE_ADR,
  output logic              TUBE_CS_B,
  output logic              TUBE_RNW_B,
  output logic              TUBE_PHI2,
  output logic              TUBE_RST_B,
  input  logic [7:0]        TUBE_DIN,
  output logic [7:0]        TUBE_DOUT,
  output logic              TUBE_DOE,
  input  logic              TUBE_INT_B,
  input  logic [GPIO_W-1:0] GPIO_IN,
  output logic [GPIO_W-1:0] GPIO_OUT,
  output logic [GPIO_W-1:0] GPIO_OE
);

  localparam int CMAX = (SETUP_CYC > PHI2_HI_CYC) ? SETUP_CYC : PHI2_HI_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = $clog2(RST_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, PHI, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      rd_latch;
  logic [7:0]      loc_rd;
  logic [RW-1:0]   rst_cnt;
  logic            wr_seen;
  logic            int_en;
  logic            pending;
  logic            int_s1, int_s2, int_s2_d;
  logic            sel, tube_sel, loc_wr, int_fall, pend_clr, rst_start;

  assign sel       = !IOREQ_B && (ADR[15:4] == PORT_TOP12) && (!RD_B || !WR_B);
  assign tube_sel  = sel && !ADR[3];
  // local writes fire once per IOREQ_B low period
  assign loc_wr    = sel && !WR_B && ADR[3] && !wr_seen;
  assign int_fall  = int_s2_d && !int_s2;
  assign pend_clr  = loc_wr && (ADR[3:0] == 4'h8) && DATA_IN[1];
  assign rst_start = loc_wr && (ADR[3:0] == 4'h9) && DATA_IN[1];

  // WAIT is raised combinationally on the first cycle so the host never misses it
  assign WAIT_REQ   = (state == IDLE && tube_sel) || state == SETUP || state == PHI;
  assign INT_B      = !(pending && int_en);
  assign TUBE_RST_B = (rst_cnt == '0);
  assign TUBE_DOUT  = DATA_IN;
  assign DATA_OE    = sel && !RD_B && (ADR[3] || state == DONE);

  // Tube access sequencer: SETUP with CS low, then PHI2 high, then hold read data until IOREQ_B rises
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      TUBE_ADR   <= '0;
      TUBE_CS_B  <= 1'b1;
      TUBE_RNW_B <= 1'b1;
      TUBE_PHI2  <= 1'b0;
      TUBE_DOE   <= 1'b0;
      rd_latch   <= '0;
    end else begin
      case (state)
        IDLE: if (tube_sel) begin
          state      <= SETUP;
          TUBE_ADR   <= ADR[2:0];
          TUBE_RNW_B <= WR_B;
          TUBE_CS_B  <= 1'b0;
          cnt        <= CW'(SETUP_CYC - 1);
        end
        SETUP: if (cnt == '0) begin
          state     <= PHI;
          TUBE_PHI2 <= 1'b1;
          TUBE_DOE  <= !TUBE_RNW_B;
          cnt       <= CW'(PHI2_HI_CYC - 1);
        end else begin
          cnt <= cnt - CW'(1);
        end
        PHI: if (cnt == '0) begin
          state      <= DONE;
          rd_latch   <= TUBE_DIN;
          TUBE_PHI2  <= 1'b0;
          TUBE_DOE   <= 1'b0;
          TUBE_CS_B  <= 1'b1;
          TUBE_RNW_B <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
        DONE: if (IOREQ_B) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Remember that a local write already happened in this IO cycle
  always_ff @(posedge CLK) begin
    if (RESET) wr_seen <= 1'b0;
    else       wr_seen <= IOREQ_B ? 1'b0 : (wr_seen || loc_wr);
  end

  // Two-flop sync of the Tube interrupt; a new falling edge beats a same-cycle clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      int_s1   <= 1'b1;
      int_s2   <= 1'b1;
      int_s2_d <= 1'b1;
      pending  <= 1'b0;
    end else begin
      int_s1   <= TUBE_INT_B;
      int_s2   <= int_s1;
      int_s2_d <= int_s2;
      if (int_fall)      pending <= 1'b1;
      else if (pend_clr) pending <= 1'b0;
    end
  end

  // Tube reset pulse counter: loaded by RESET and by software, restarts on rewrite
  always_ff @(posedge CLK) begin
    if (RESET)               rst_cnt <= RW'(RST_CYC);
    else if (rst_start)      rst_cnt <= RW'(RST_CYC);
    else if (rst_cnt != '0)  rst_cnt <= rst_cnt - RW'(1);
  end

  // CTRL, DIR and DATA register writes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      int_en   <= 1'b0;
      GPIO_OE  <= '0;
      GPIO_OUT <= '0;
    end else if (loc_wr) begin
      case (ADR[3:0])
        4'h9:    int_en   <= DATA_IN[0];
        4'hE:    GPIO_OE  <= DATA_IN[GPIO_W-1:0];
        4'hF:    GPIO_OUT <= DATA_IN[GPIO_W-1:0];
        default: ;
      endcase
    end
  end

  // Host read mux: local registers by address, otherwise the latched Tube data
  always_comb begin
    loc_rd = '0;
    case (ADR[3:0])
      4'h8: loc_rd = {5'b0, (state != IDLE), pending, !int_s2};
      4'h9: loc_rd = {6'b0, (rst_cnt != '0), int_en};
      4'hE: loc_rd[GPIO_W-1:0] = GPIO_OE;
      4'hF: loc_rd[GPIO_W-1:0] = GPIO_IN;
      default: loc_rd = '0;
    endcase
    DATA_OUT = ADR[3] ? loc_rd : rd_latch;
  end

endmodule

// File: tb/tb_z80_tube_bridge_p.sv
module tb_z80_tube_bridge_p;

  logic        CLK, RESET;
  logic [15:0] ADR;
  logic        IOREQ_B, RD_B, WR_B;
  logic [7:0]  DATA_IN, DATA_OUT;
  logic        DATA_OE, WAIT_REQ, INT_B;
  logic [2:0]  TUBE_ADR;
  logic        TUBE_CS_B, TUBE_RNW_B, TUBE_PHI2, TUBE_RST_B;
  logic [7:0]  TUBE_DIN, TUBE_DOUT;
  logic        TUBE_DOE, TUBE_INT_B;
  logic [3:0]  GPIO_IN, GPIO_OUT, GPIO_OE;

  int checks = 0;
  int errors = 0;

  z80_tube_bridge_p #(.PORT_TOP12(12'hFC1), .GPIO_W(4), .SETUP_CYC(1),
                      .PHI2_HI_CYC(2), .RST_CYC(16)) dut (
    .CLK(CLK), .RESET(RESET), .ADR(ADR), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .WAIT_REQ(WAIT_REQ),
    .INT_B(INT_B), .TUBE_ADR(TUBE_ADR), .TUBE_CS_B(TUBE_CS_B), .TUBE_RNW_B(TUBE_RNW_B),
    .TUBE_PHI2(TUBE_PHI2), .TUBE_RST_B(TUBE_RST_B), .TUBE_DIN(TUBE_DIN),
    .TUBE_DOUT(TUBE_DOUT), .TUBE_DOE(TUBE_DOE), .TUBE_INT_B(TUBE_INT_B),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle;
    IOREQ_B = 1'b1;
    RD_B    = 1'b1;
    WR_B    = 1'b1;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [7:0] d);
    ADR = a; DATA_IN = d; IOREQ_B = 1'b0; WR_B = 1'b0;
    tick;
    tick;
    bus_idle;
    tick;
  endtask

  task automatic host_read(input logic [15:0] a, output logic [7:0] d);
    ADR = a; IOREQ_B = 1'b0; RD_B = 1'b0;
    #1;
    d = DATA_OUT;
    bus_idle;
    tick;
  endtask

  task automatic test_reset;
    int n;
    RESET = 1'b1;
    bus_idle;
    repeat (3) tick;
    checks++;
    if ({TUBE_CS_B, TUBE_RNW_B, TUBE_PHI2, TUBE_DOE, WAIT_REQ, INT_B, DATA_OE, TUBE_RST_B} !== 8'b1100_0100) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 11000100",
               {TUBE_CS_B, TUBE_RNW_B, TUBE_PHI2, TUBE_DOE, WAIT_REQ, INT_B, DATA_OE, TUBE_RST_B});
    end
    checks++;
    if ({GPIO_OE, GPIO_OUT} !== 8'h00) begin
      errors++;
      $display("FAIL reset_gpio: got oe=%h out=%h expected 0 0", GPIO_OE, GPIO_OUT);
    end
    RESET = 1'b0;
    n = 0;
    while (!TUBE_RST_B && n < 100) begin tick; n++; end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL reset_tube_rst_len: got %0d cycles expected 16", n);
    end
  endtask

  task automatic test_tube_write;
    int wc, cc, pc;
    wc = 0; cc = 0; pc = 0;
    ADR = 16'hFC13; DATA_IN = 8'h5A; IOREQ_B = 1'b0; WR_B = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (WAIT_REQ)   wc++;
      if (!TUBE_CS_B) cc++;
      if (TUBE_PHI2) begin
        pc++;
        checks++;
        if ({TUBE_DOUT, TUBE_ADR, TUBE_RNW_B, TUBE_DOE} !== {8'h5A, 3'd3, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL wr_phi_bus: got dout=%h adr=%0d rnw=%b doe=%b expected 5a 3 0 1",
                   TUBE_DOUT, TUBE_ADR, TUBE_RNW_B, TUBE_DOE);
        end
      end
      @(posedge CLK);
      #1;
    end
    checks++;
    if (wc != 4) begin errors++; $display("FAIL wr_wait_len: got %0d expected 4", wc); end
    checks++;
    if (cc != 3) begin errors++; $display("FAIL wr_cs_len: got %0d expected 3", cc); end
    checks++;
    if (pc != 2) begin errors++; $display("FAIL wr_phi2_len: got %0d expected 2", pc); end
    bus_idle;
    tick;
  endtask

  task automatic test_tube_read;
    int n;
    logic [7:0] d;
    ADR = 16'hFC15; TUBE_DIN = 8'hA7; IOREQ_B = 1'b0; RD_B = 1'b0;
    #1;
    n = 0;
    while (WAIT_REQ && n < 20) begin @(posedge CLK); #1; n++; end
    checks++;
    if (n != 4) begin errors++; $display("FAIL rd_wait_len: got %0d expected 4", n); end
    checks++;
    if ({DATA_OE, DATA_OUT} !== {1'b1, 8'hA7}) begin
      errors++;
      $display("FAIL rd_data: got oe=%b data=%h expected 1 a7", DATA_OE, DATA_OUT);
    end
    TUBE_DIN = 8'h00;
    tick;
    checks++;
    if ({DATA_OE, DATA_OUT} !== {1'b1, 8'hA7}) begin
      errors++;
      $display("FAIL rd_data_held: got oe=%b data=%h expected 1 a7", DATA_OE, DATA_OUT);
    end
    bus_idle;
    #1;
    checks++;
    if (DATA_OE !== 1'b0) begin errors++; $display("FAIL rd_oe_release: got %b expected 0", DATA_OE); end
    tick;
    host_read(16'hFC18, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rd_status_idle: got %h expected 00", d); end
  endtask

  task automatic test_gpio;
    logic [7:0] d;
    host_write(16'hFC1E, 8'hFF);
    host_write(16'hFC1F, 8'h0C);
    checks++;
    if ({GPIO_OE, GPIO_OUT} !== 8'hFC) begin
      errors++;
      $display("FAIL gpio_regs: got oe=%h out=%h expected f c", GPIO_OE, GPIO_OUT);
    end
    host_read(16'hFC1E, d);
    checks++;
    if (d !== 8'h0F) begin errors++; $display("FAIL gpio_dir_read: got %h expected 0f", d); end
    GPIO_IN = 4'h5;
    host_read(16'hFC1F, d);
    checks++;
    if (d !== 8'h05) begin errors++; $display("FAIL gpio_in_read: got %h expected 05", d); end
    host_read(16'hFC1A, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL unused_reg_read: got %h expected 00", d); end
    ADR = 16'hFC1F; DATA_IN = 8'h03; IOREQ_B = 1'b0; WR_B = 1'b0;
    tick;
    DATA_IN = 8'h0A;
    tick;
    tick;
    checks++;
    if (GPIO_OUT !== 4'h3) begin errors++; $display("FAIL write_once: got %h expected 3", GPIO_OUT); end
    bus_idle;
    tick;
  endtask

  task automatic test_interrupt;
    int n;
    logic [7:0] d;
    host_write(16'hFC19, 8'h01);
    TUBE_INT_B = 1'b0;
    n = 0;
    while (INT_B && n < 20) begin tick; n++; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL int_latency: got %0d expected 3", n); end
    host_read(16'hFC18, d);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL int_status: got %h expected 03", d); end
    host_write(16'hFC18, 8'h02);
    checks++;
    if (INT_B !== 1'b1) begin errors++; $display("FAIL int_clear: got %b expected 1", INT_B); end
    host_read(16'hFC18, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL int_status_cleared: got %h expected 01", d); end
    TUBE_INT_B = 1'b1;
    repeat (4) tick;
    TUBE_INT_B = 1'b0;
    tick;
    tick;
    ADR = 16'hFC18; DATA_IN = 8'h02; IOREQ_B = 1'b0; WR_B = 1'b0;
    tick;
    bus_idle;
    #1;
    checks++;
    if (INT_B !== 1'b0) begin errors++; $display("FAIL int_set_wins: got INT_B=%b expected 0", INT_B); end
    host_read(16'hFC18, d);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL int_set_wins_status: got %h expected 03", d); end
    host_write(16'hFC18, 8'h02);
    TUBE_INT_B = 1'b1;
    host_write(16'hFC19, 8'h00);
    repeat (3) tick;
  endtask

  task automatic test_reset_mid_access;
    int n;
    ADR = 16'hFC11; DATA_IN = 8'h33; IOREQ_B = 1'b0; WR_B = 1'b0;
    tick;
    tick;
    checks++;
    if (TUBE_PHI2 !== 1'b1) begin errors++; $display("FAIL mid_in_phi: got %b expected 1", TUBE_PHI2); end
    RESET = 1'b1;
    bus_idle;
    tick;
    checks++;
    if ({TUBE_CS_B, TUBE_PHI2, WAIT_REQ, TUBE_DOE} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_abort: got cs=%b phi2=%b wait=%b doe=%b expected 1 0 0 0",
               TUBE_CS_B, TUBE_PHI2, WAIT_REQ, TUBE_DOE);
    end
    ADR = 16'hFC18; IOREQ_B = 1'b0; RD_B = 1'b0;
    #1;
    checks++;
    if (DATA_OUT[2] !== 1'b0) begin errors++; $display("FAIL mid_idle: got busy=%b expected 0", DATA_OUT[2]); end
    bus_idle;
    RESET = 1'b0;
    n = 0;
    while (!TUBE_RST_B && n < 40) begin tick; n++; end
    checks++;
    if (TUBE_RST_B !== 1'b1) begin errors++; $display("FAIL mid_rst_release: got %b expected 1", TUBE_RST_B); end
    ADR = 16'hFC19; DATA_IN = 8'h02; IOREQ_B = 1'b0; WR_B = 1'b0;
    tick;
    bus_idle;
    n = 0;
    while (!TUBE_RST_B && n < 40) begin tick; n++; end
    checks++;
    if (n != 16) begin errors++; $display("FAIL sw_rst_len: got %0d cycles expected 16", n); end
  endtask

  initial begin
    RESET = 1'b1; ADR = 16'h0000; DATA_IN = 8'h00; TUBE_DIN = 8'h00;
    TUBE_INT_B = 1'b1; GPIO_IN = 4'h0;
    bus_idle;
    test_reset;
    test_tube_write;
    test_tube_read;
    test_gpio;
    test_interrupt;
    test_reset_mid_access;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
